// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: grants one of two writeback requesters onto a registered
// register-file write port and tracks pending destination registers.
// Define WB_ARB_RR_EN for round-robin contention; otherwise b has fixed priority.
module reg_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        write_reg_enable,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_write_data,
  input  logic        mark_valid,
  input  logic [4:0]  mark_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy
);

  logic        contend_a;
  logic        xfer;
  logic        xfer_wr;
  logic [4:0]  xfer_addr;
  logic [31:0] xfer_data;
  logic [31:0] busy;
  logic [31:0] busy_next;

`ifdef WB_ARB_RR_EN
  typedef enum logic {PREF_B = 1'b0, PREF_A = 1'b1} pref_t;
  pref_t pref;
  pref_t pref_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pref <= PREF_B;
    else     pref <= pref_next;
  end

  always_comb begin
    pref_next = pref;
    if (a_valid && b_valid)
      pref_next = (pref == PREF_B) ? PREF_A : PREF_B;
  end

  assign contend_a = (pref == PREF_A);
`else
  assign contend_a = 1'b0;
`endif

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      if (a_valid && (!b_valid || contend_a)) a_ready = 1'b1;
      else if (b_valid)                       b_ready = 1'b1;
    end
  end

  assign xfer      = a_ready | b_ready;
  assign xfer_addr = a_ready ? a_addr : b_addr;
  assign xfer_data = a_ready ? a_data : b_data;
  assign xfer_wr   = xfer && (xfer_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg_enable <= 1'b0;
      rd_addr          <= '0;
      rd_write_data    <= '0;
    end else begin
      write_reg_enable <= xfer_wr;
      if (xfer_wr) begin
        rd_addr       <= xfer_addr;
        rd_write_data <= xfer_data;
      end
    end
  end

  // Set is applied after clear so a fresh reservation survives a same-edge retire.
  always_comb begin
    busy_next = busy;
    if (xfer_wr) busy_next[xfer_addr] = 1'b0;
    if (mark_valid && (mark_addr != '0)) busy_next[mark_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameters: none; all widths fixed (5-bit register address, 32-bit data).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a_valid / a_addr / a_data  input  1/5/32  ALU writeback request: valid, destination register, data.
REQ-005 a_ready  output  1  ALU request accepted this cycle.
REQ-006 b_valid / b_addr / b_data  input  1/5/32  memory/cache writeback request: valid, destination register, data.
REQ-007 b_ready  output  1  memory request accepted this cycle.
REQ-008 write_reg_enable / rd_addr / rd_write_data  output  1/5/32  registered write port driving the register file.
REQ-009 mark_valid / mark_addr  input  1/5  issue stage reserves a destination register (pending write).
REQ-010 rs1_addr / rs2_addr  input  5/5  source registers queried by decode.
REQ-011 rs1_busy / rs2_busy  output  1/1  queried source has a pending write.

Function
REQ-012 Handshake: a request transfers when valid and ready are both high at a rising edge; the requester SHALL hold addr/data stable while valid is high and ready is low.
REQ-013 ready is combinational from the valids and the priority state; at most one of a_ready/b_ready is high per cycle; a lone valid requester is always granted.
REQ-014 Contention (both valid) without round-robin: b wins; a_ready low.
REQ-015 Write latency: transfer at edge N drives write_reg_enable=1, rd_addr, rd_write_data for exactly cycle N..N+1 (one cycle, registered); no transfer -> write_reg_enable=0, rd_addr/rd_write_data hold last value.
REQ-016 Transfer with addr 0: accepted (ready high), write_reg_enable stays 0, scoreboard unchanged.
REQ-017 Scoreboard: 32 busy bits; bit[0] constant 0.
REQ-018 mark_valid with mark_addr!=0 sets bit[mark_addr] at the edge.
REQ-019 A transfer to register r clears bit[r] at the same edge.
REQ-020 Same-edge set and clear of the same register: set wins (newer reservation pending).
REQ-021 rsX_busy = bit[rsX_addr] registered state only (no same-cycle bypass of clears or sets); rsX_addr=0 -> 0.
REQ-022 mark_valid on an already-busy register: bit stays 1, no error flag.
REQ-023 Transfer to a non-busy register: performed normally, bit stays 0.

Reset
REQ-024 rst high: all busy bits 0, write_reg_enable=0, rd_addr=0, rd_write_data=0, round-robin pointer selects b; takes effect immediately without clock.
REQ-025 While rst high: a_ready=b_ready=0, no transfer, mark ignored.
REQ-026 Reset mid-operation: a write registered but not yet presented is discarded; first transfer possible at the first edge after rst deasserts.

Configuration
REQ-027 Macro WB_ARB_RR_EN defined: contention resolved round-robin; a 1-bit pointer names the preferred requester, flips to the other requester after each contested grant, unchanged by uncontested grants.
REQ-028 WB_ARB_RR_EN undefined: fixed priority b over a (REQ-014); pointer logic absent.

Verification
REQ-029 After reset, a_valid=1 a_addr=5 a_data=0x0000_1234 one cycle -> a_ready=1; next cycle write_reg_enable=1 rd_addr=5 rd_write_data=0x0000_1234; following cycle write_reg_enable=0.
REQ-030 a and b valid 4 cycles, addrs 3/7 -> fixed: b granted all 4, a_ready=0; WB_ARB_RR_EN: grants b,a,b,a.
REQ-031 mark_valid addr 9; next cycle rs1_addr=9 -> rs1_busy=1; b transfer to 9 -> rs1_busy=0 the cycle after; same-edge mark 9 and transfer to 9 -> rs1_busy stays 1.
REQ-032 a transfer addr 0 data 0xFFFF_FFFF -> a_ready=1, write_reg_enable stays 0; mark addr 0 -> rs2_addr=0 reports rs2_busy=0.
REQ-033 Mark 4, transfer to 4 accepted, rst pulsed asynchronously mid-cycle before next edge -> write_reg_enable=0, rd_write_data=0, all busy 0 immediately; no write appears after release.
